hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the pipeline hazard unit. It tracks the E/M/W stages internally as a scoreboard of in-flight register writes, so it no longer takes per-stage Tnew inputs. From that state it produces the D-stage stall and per-read-port forward selects. It also adds a built-in multi-cycle MDU busy counter, which implements the HI/LO (MD) stall. It sits beside the D stage and drives the stall/flush of the D/E register and the D/E forward muxes.

## Interface
Parameters:
- `NUM_RD_PORTS`, 2: D-stage register read ports.
- `REG_AW`, 5: register address width; address 0 never matches.
- `TNEW_W`, 2: Tnew/Tuse width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: async active-high; clears all state.
- `rd_addr_d` in NUM_RD_PORTS*REG_AW: packed D read addresses; port i is at [i*REG_AW +: REG_AW].
- `tuse_d` in NUM_RD_PORTS*TNEW_W: packed Tuse per port.
- `wr_en_d` in 1: the D instruction writes a GPR.
- `wr_addr_d` in REG_AW: D destination register.
- `tnew_d` in TNEW_W: Tnew the instruction will have on entering E.
- `md_start_d` in 1: the D instruction is mult/div.
- `md_is_div_d` in 1: selects DIV_CYCLES; otherwise MULT_CYCLES.
- `md_use_d` in 1: the D instruction reads or writes HI/LO or is an MD op.
- `flush` in 1: insert a bubble into E this cycle.
- `stall` out 1: hold F/D and bubble E.
- `fwd_sel_d` out NUM_RD_PORTS*2: per-port source; 0 = RF, 1 = E, 2 = M, 3 = W.
- `md_busy` out 1: MDU counter is nonzero.

## Operation
- Scoreboard has slots E, M and W. Each slot holds {valid, dst, tnew}. A slot counts only if valid and dst != 0.
- Every clock edge, with no enable:
  - W <= M.
  - M <= E, with tnew decremented and saturating at 0.
  - E <= bubble if `stall` or `flush`. Otherwise E <= {wr_en_d, wr_addr_d, tnew_d}.
- W tnew is always treated as 0.
- GPR stall: for any port i with rd_addr != 0, stall if the nearest matching slot (E before M before W) has tuse_i < tnew. A match in a farther slot is ignored when a nearer slot matches.
- Forward select for port i is the index of the nearest matching slot when that slot's tnew == 0. Otherwise it is 0, meaning the RF handles it, including RF internal bypass.
- MD counter:
  - Loads on the edge where md_start_d && !stall && !flush. The load value is DIV_CYCLES if md_is_div_d, else MULT_CYCLES.
  - Otherwise it decrements while nonzero.
  - `md_busy` = (counter != 0).
- MD stall: md_use_d && md_busy.
- `stall` = GPR stall OR MD stall.
- Simultaneous events:
  - flush and stall together: E is a bubble and the counter does not load.
  - md_start_d while md_busy: md_use_d must be asserted, so it stalls and no reload occurs.
- Reset mid-operation: all slots become invalid, counter goes to 0, and the in-flight MD op is abandoned.

## Timing
- `stall` and `fwd_sel_d` are combinational from D inputs and registered state, with no input-to-output register.
- Slot state and the counter update at posedge clk.
- Reset values: stall = 0, fwd_sel_d = 0, md_busy = 0. All slots are invalid.
- MD op accepted at edge t: md_busy is high for exactly N cycles starting at t, where N is MULT_CYCLES or DIV_CYCLES. It falls on the edge t+N.
- A load whose tnew_d = 2 in E stalls a dependent Tuse = 0 reader for 2 cycles. The reader then receives fwd_sel = 3 (W).
- The counter width is the minimum that holds max(MULT_CYCLES, DIV_CYCLES). The decrement never wraps below 0.

## Configuration
- `HAZARD_W_FWD_EN` defined: the W slot is a forward source, so fwd_sel can be 3.
- `HAZARD_W_FWD_EN` undefined:
  - A W match yields 0, and the RF internal bypass is required.
  - The W slot still shadows farther matches. Only M and E matches take priority over it.
  - Stall behaviour is identical in both builds.

## Structure
- Shared package `hazard_pkg` holds:
  - The constants FWD_RF/FWD_E/FWD_M/FWD_W.
  - The slot typedef {valid, dst, tnew}.
  - The stage index constants.
- Sub-module `md_busy_counter` holds the load/decrement counter and busy flag. It is parametrised by MULT_CYCLES and DIV_CYCLES.
- Scoreboard shift and match/priority logic live in the top level, with one generate loop per read port.

## Test plan
- Reset with MD busy and slots valid: assert reset asynchronously mid-cycle. Required: stall = 0, md_busy = 0 and fwd_sel = 0 immediately, before the next edge.
- ALU write to $5 (tnew 1) followed by a reader of $5 with tuse 0: stall for 1 cycle, then fwd_sel port0 = 2 (M).
- Load to $8 (tnew 2) followed by a reader with tuse 1: 1 stall cycle. Then fwd_sel = 3 with the macro defined, or 0 without it.
- Writes to $3 in both E (tnew 0) and M (tnew 0): fwd_sel = 1. A reader of $0 always gets 0 and never stalls.
- div accepted at cycle 0, followed by mfhi (md_use_d): md_busy is high for 10 cycles and stall is high for cycles 1–10. The counter does not reload during that time.
- flush together with md_start_d: E becomes a bubble and md_busy stays 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forward-source codes, stage
// indices and the scoreboard slot record.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam int STG_E   = 0;
    localparam int STG_M   = 1;
    localparam int STG_W   = 2;
    localparam int NUM_STG = 3;

    // Slot fields are sized for the widest supported configuration; narrower
    // addresses and Tnew values are zero-extended into them.
    localparam int SLOT_AW = 8;
    localparam int SLOT_TW = 4;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] dst;
        logic [SLOT_TW-1:0] tnew;
    } slot_t;

    function automatic slot_t slot_age(input slot_t s);
        slot_t r;
        r = s;
        if (s.tnew != '0) r.tnew = s.tnew - SLOT_TW'(1);
        return r;
    endfunction

    function automatic logic slot_match(input slot_t s, input logic [SLOT_AW-1:0] addr);
        return s.valid && (s.dst != '0) && (s.dst == addr);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multi-cycle MDU busy counter: loads the op latency on acceptance and counts
// down to zero; busy while nonzero.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit tracking in-flight E/M/W register writes; produces stall
// and per-port forward selects. Define HAZARD_W_FWD_EN to forward from W.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int REG_AW       = 5,
    parameter int TNEW_W       = 2,
    parameter int MULT_CYCLES  = 5,
    parameter int DIV_CYCLES   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] rd_addr_d,
    input  logic [NUM_RD_PORTS*TNEW_W-1:0] tuse_d,
    input  logic                         wr_en_d,
    input  logic [REG_AW-1:0]            wr_addr_d,
    input  logic [TNEW_W-1:0]            tnew_d,
    input  logic                         md_start_d,
    input  logic                         md_is_div_d,
    input  logic                         md_use_d,
    input  logic                         flush,
    output logic                         stall,
    output logic [NUM_RD_PORTS*2-1:0]    fwd_sel_d,
    output logic                         md_busy
);

    slot_t                   sb [NUM_STG];
    slot_t                   d_slot;
    logic [NUM_RD_PORTS-1:0] port_stall;
    logic                    gpr_stall;
    logic                    md_stall;
    logic                    md_load;

    always_comb begin
        d_slot       = '0;
        d_slot.valid = wr_en_d;
        d_slot.dst   = SLOT_AW'(wr_addr_d);
        d_slot.tnew  = SLOT_TW'(tnew_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_STG; s++) sb[s] <= '0;
        end else begin
            sb[STG_W] <= sb[STG_M];
            sb[STG_M] <= slot_age(sb[STG_E]);
            sb[STG_E] <= (stall || flush) ? '0 : d_slot;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [SLOT_AW-1:0] ra;
        logic [SLOT_TW-1:0] tu;
        logic               hit;
        logic [SLOT_TW-1:0] near_tnew;
        logic [1:0]         near_src;

        assign ra = SLOT_AW'(rd_addr_d[p*REG_AW +: REG_AW]);
        assign tu = SLOT_TW'(tuse_d[p*TNEW_W +: TNEW_W]);

        // Nearest stage wins; W always counts as ready (tnew 0).
        always_comb begin
            hit       = 1'b0;
            near_tnew = '0;
            near_src  = FWD_RF;
            if (slot_match(sb[STG_E], ra)) begin
                hit       = 1'b1;
                near_tnew = sb[STG_E].tnew;
                near_src  = FWD_E;
            end else if (slot_match(sb[STG_M], ra)) begin
                hit       = 1'b1;
                near_tnew = sb[STG_M].tnew;
                near_src  = FWD_M;
            end else if (slot_match(sb[STG_W], ra)) begin
                hit       = 1'b1;
`ifdef HAZARD_W_FWD_EN
                near_src  = FWD_W;
`else
                near_src  = FWD_RF;
`endif
            end
        end

        assign port_stall[p]       = hit && (tu < near_tnew);
        assign fwd_sel_d[p*2 +: 2] = (hit && (near_tnew == '0)) ? near_src : FWD_RF;
    end

    assign gpr_stall = |port_stall;
    assign md_stall  = md_use_d && md_busy;
    assign stall     = gpr_stall || md_stall;
    assign md_load   = md_start_d && !stall && !flush;

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .load  (md_load),
        .is_div(md_is_div_d),
        .busy  (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table plus
// hand-written div-latency and asynchronous-reset sequences.
module tb_hazard_scoreboard;

    localparam int NP = 2;
    localparam int AW = 5;
    localparam int TW = 2;
`ifdef HAZARD_W_FWD_EN
    localparam logic [1:0] W_F = 2'd3;
`else
    localparam logic [1:0] W_F = 2'd0;
`endif

    logic              clk;
    logic              reset;
    logic [NP*AW-1:0]  rd_addr_d;
    logic [NP*TW-1:0]  tuse_d;
    logic              wr_en_d;
    logic [AW-1:0]     wr_addr_d;
    logic [TW-1:0]     tnew_d;
    logic              md_start_d;
    logic              md_is_div_d;
    logic              md_use_d;
    logic              flush;
    logic              stall;
    logic [NP*2-1:0]   fwd_sel_d;
    logic              md_busy;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_d  (rd_addr_d),
        .tuse_d     (tuse_d),
        .wr_en_d    (wr_en_d),
        .wr_addr_d  (wr_addr_d),
        .tnew_d     (tnew_d),
        .md_start_d (md_start_d),
        .md_is_div_d(md_is_div_d),
        .md_use_d   (md_use_d),
        .flush      (flush),
        .stall      (stall),
        .fwd_sel_d  (fwd_sel_d),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [NP*AW-1:0] rd;
        logic [NP*TW-1:0] tuse;
        logic             we;
        logic [AW-1:0]    wa;
        logic [TW-1:0]    tn;
        logic             ms;
        logic             mdv;
        logic             mu;
        logic             fl;
        logic             exp_stall;
        logic [NP*2-1:0]  exp_fwd;
        logic             exp_busy;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];

    function automatic vec_t mk(input int rd0, input int tu0, input int rd1, input int tu1,
                                input int we, input int wa, input int tn,
                                input int ms, input int mdv, input int mu, input int fl,
                                input int es, input logic [1:0] f0, input logic [1:0] f1,
                                input int eb);
        vec_t v;
        v.rd        = {AW'(rd1), AW'(rd0)};
        v.tuse      = {TW'(tu1), TW'(tu0)};
        v.we        = 1'(we);
        v.wa        = AW'(wa);
        v.tn        = TW'(tn);
        v.ms        = 1'(ms);
        v.mdv       = 1'(mdv);
        v.mu        = 1'(mu);
        v.fl        = 1'(fl);
        v.exp_stall = 1'(es);
        v.exp_fwd   = {f1, f0};
        v.exp_busy  = 1'(eb);
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        rd_addr_d   = v.rd;
        tuse_d      = v.tuse;
        wr_en_d     = v.we;
        wr_addr_d   = v.wa;
        tnew_d      = v.tn;
        md_start_d  = v.ms;
        md_is_div_d = v.mdv;
        md_use_d    = v.mu;
        flush       = v.fl;
    endtask

    task automatic idle_inputs();
        rd_addr_d   = '0;
        tuse_d      = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        tnew_d      = '0;
        md_start_d  = 1'b0;
        md_is_div_d = 1'b0;
        md_use_d    = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic es, input logic [NP*2-1:0] ef,
                                 input logic eb);
        check($sformatf("%s_stall", tag), 8'(stall), 8'(es));
        check($sformatf("%s_fwd", tag), 8'(fwd_sel_d), 8'(ef));
        check($sformatf("%s_busy", tag), 8'(md_busy), 8'(eb));
    endtask

    initial begin
        // Each row is one D-stage cycle; rows run back to back from reset.
        //              rd0 tu rd1 tu we wa tn ms dv mu fl  st f0   f1   bz
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[2]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        vecs[3]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0);
        vecs[4]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, W_F,  2'd0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 8, 2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[6]  = mk(0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        vecs[7]  = mk(0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[8]  = mk(0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, W_F,  0);
        vecs[9]  = mk(0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[10] = mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        vecs[11] = mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        vecs[12] = mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, W_F,  2'd0, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[15] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0);
        vecs[16] = mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 0);
        vecs[17] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, W_F,  2'd0, 0);
        vecs[18] = mk(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[19] = mk(0, 0, 0, 0, 1, 7, 2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[20] = mk(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        vecs[21] = mk(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[22] = mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[24] = mk(0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0);
        vecs[25] = mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 1);
        vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 1);
        vecs[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 1);
        vecs[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 1);
        vecs[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 1);
        vecs[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0);
        vecs[35] = mk(0, 0, 0, 0, 1, 4, 2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        vecs[36] = mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 2'd0, 2'd0, 0);
        vecs[37] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("reset", 1'b0, '0, 1'b0);
        #2 reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            @(negedge clk);
            check_outputs($sformatf("v%0d", i), vecs[i].exp_stall, vecs[i].exp_fwd,
                          vecs[i].exp_busy);
        end

        // div accepted, then mfhi-style readers that also keep md_start high.
        @(posedge clk);
        #1 idle_inputs();
        md_start_d  = 1'b1;
        md_is_div_d = 1'b1;
        md_use_d    = 1'b1;
        @(negedge clk);
        check_outputs("div_accept", 1'b0, '0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_outputs($sformatf("div_c%0d", c), 1'b1, '0, 1'b1);
        end
        @(posedge clk);
        #1 md_start_d = 1'b0;
        @(negedge clk);
        check_outputs("div_done", 1'b0, '0, 1'b0);

        // Asynchronous reset with a live E slot and a running mult.
        @(posedge clk);
        #1 idle_inputs();
        wr_en_d    = 1'b1;
        wr_addr_d  = AW'(5);
        md_start_d = 1'b1;
        @(negedge clk);
        check_outputs("rst_setup", 1'b0, '0, 1'b0);
        @(posedge clk);
        #1 idle_inputs();
        rd_addr_d = {AW'(0), AW'(5)};
        md_use_d  = 1'b1;
        @(negedge clk);
        check_outputs("rst_pre", 1'b1, {2'd0, 2'd1}, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_outputs("rst_async", 1'b0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_outputs("rst_after", 1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
